// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one ready-handshaked memory port between IF fetch and ME load/store,
// with data-over-fetch priority, a fetch starvation guard and a bus timeout.
`default_nettype none

module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int TIMEOUT    = 255,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_done,
  output logic                if_err,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_done,
  output logic                d_err,
  output logic                mem_valid,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_ready,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy,
  output logic                owner
);

  localparam int STRB_W = DATA_W / 8;
  localparam int TCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int SCNT_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);
  localparam logic [SCNT_W-1:0] SCNT_MAX  = SCNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                owner_q, owner_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                err_q, err_d;
  logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
  logic [SCNT_W-1:0]   scnt_q, scnt_d;
  logic                fetch_wins;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      owner_q    <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      err_q      <= 1'b0;
      tcnt_q     <= '0;
      scnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      err_q      <= err_d;
      tcnt_q     <= tcnt_d;
      scnt_q     <= scnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    err_d      = err_q;
    tcnt_d     = tcnt_q;
    scnt_d     = scnt_q;
    fetch_wins = if_req && (!d_req || (scnt_q == SCNT_MAX));

    case (state_q)
      S_IDLE: begin
        if (if_req || d_req) begin
          owner_d = !fetch_wins;
          tcnt_d  = '0;
          state_d = S_ACCESS;
          if (fetch_wins) begin
            addr_d  = if_addr;
            we_d    = 1'b0;
            wstrb_d = '0;
            scnt_d  = '0;
          end else begin
            addr_d  = d_addr;
            we_d    = d_we;
            wdata_d = d_wdata;
            wstrb_d = d_we ? d_wstrb : '0;
            if (if_req && (scnt_q != SCNT_MAX)) begin
              scnt_d = scnt_q + SCNT_W'(1);
            end
          end
        end
      end
      S_ACCESS: begin
        // ready takes precedence over a timeout expiring on the same edge
        if (mem_ready) begin
          if (!we_q) begin
            if (owner_q) d_rdata_d  = mem_rdata;
            else         if_rdata_d = mem_rdata;
          end
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if ((TIMEOUT != 0) && (tcnt_q == TCNT_LAST)) begin
          if (owner_q) d_rdata_d  = '0;
          else         if_rdata_d = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          tcnt_d = tcnt_q + TCNT_W'(1);
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign mem_valid = (state_q == S_ACCESS);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wstrb = wstrb_q;
  assign busy      = (state_q != S_IDLE);
  assign owner     = owner_q;
  assign if_done   = (state_q == S_RESP) && !owner_q;
  assign d_done    = (state_q == S_RESP) && owner_q;
  assign if_err    = if_done && err_q;
  assign d_err     = d_done && err_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized fetch/data traffic against a memory model and a
// transaction-level arbitration model; responses checked through scoreboard queues.
`default_nettype none

module tb_mem_port_arbiter;

  localparam int TIMEOUT    = 8;
  localparam int STARVE_MAX = 4;

  logic        clk;
  logic        resetn;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        if_err;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic [31:0] d_rdata;
  logic        d_done;
  logic        d_err;
  logic        mem_valid;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        owner;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .resetn(resetn),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_rdata(d_rdata), .d_done(d_done), .d_err(d_err),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .busy(busy), .owner(owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        keep;
  } exp_t;

  exp_t        if_q[$];
  exp_t        d_q[$];
  logic [31:0] mem_arr [0:63];
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Request levels and payloads as seen by the arbiter at each rising edge
  logic        s_if = 1'b0, s_d = 1'b0, s_dwe = 1'b0;
  logic [31:0] s_iaddr = '0, s_daddr = '0, s_dwdata = '0;
  logic [3:0]  s_dwstrb = '0;
  always @(posedge clk) begin
    s_if     <= if_req;
    s_d      <= d_req;
    s_iaddr  <= if_addr;
    s_daddr  <= d_addr;
    s_dwe    <= d_we;
    s_dwdata <= d_wdata;
    s_dwstrb <= d_wstrb;
  end

  // Memory model plus grant prediction: one bus transaction at a time
  logic        in_txn = 1'b0, cur_owner = 1'b0, force_hang = 1'b0;
  logic        e_we = 1'b0;
  logic [3:0]  e_wstrb = '0;
  logic [31:0] e_addr = '0, e_wdata = '0, rd_val = '0;
  int          cnt = 0, exp_len = 0, w = 0, starve = 0;

  always @(negedge clk) begin
    exp_t e;
    int   idx;
    int   r;
    if (!resetn) begin
      if (in_txn) begin
        if (cur_owner && d_q.size() > 0) void'(d_q.pop_back());
        if (!cur_owner && if_q.size() > 0) void'(if_q.pop_back());
      end
      in_txn    = 1'b0;
      starve    = 0;
      mem_ready = 1'b0;
    end else if (mem_valid) begin
      if (!in_txn) begin
        check("grant_had_request", {31'd0, s_if | s_d}, 32'd1);
        cur_owner = (s_if && (!s_d || starve == STARVE_MAX)) ? 1'b0 : 1'b1;
        if (!cur_owner) starve = 0;
        else if (s_if && starve < STARVE_MAX) starve++;
        check("grant_owner", {31'd0, owner}, {31'd0, cur_owner});
        if (!cur_owner) begin
          e_addr = s_iaddr; e_we = 1'b0; e_wstrb = 4'd0; e_wdata = 32'd0;
        end else begin
          e_addr = s_daddr; e_we = s_dwe; e_wstrb = s_dwe ? s_dwstrb : 4'd0; e_wdata = s_dwdata;
        end
        r = $urandom_range(0, 9);
        if (force_hang)  w = 1000;
        else if (r < 4)  w = 0;
        else if (r == 6) w = TIMEOUT - 1;
        else if (r == 7) w = TIMEOUT;
        else             w = $urandom_range(1, 4);
        idx     = int'(e_addr[7:2]);
        rd_val  = mem_arr[idx];
        e.err   = (w >= TIMEOUT);
        e.keep  = 1'b0;
        e.rdata = 32'd0;
        if (!e.err) begin
          if (e_we) begin
            e.keep = 1'b1;
            for (int b = 0; b < 4; b++)
              if (e_wstrb[b]) mem_arr[idx][8*b +: 8] = e_wdata[8*b +: 8];
          end else begin
            e.rdata = rd_val;
          end
        end
        exp_len = e.err ? TIMEOUT : w + 1;
        if (cur_owner) d_q.push_back(e);
        else           if_q.push_back(e);
        in_txn = 1'b1;
        cnt    = 0;
      end
      cnt++;
      check("bus_addr", mem_addr, e_addr);
      check("bus_we", {31'd0, mem_we}, {31'd0, e_we});
      check("bus_wstrb", {28'd0, mem_wstrb}, {28'd0, e_wstrb});
      if (e_we) check("bus_wdata", mem_wdata, e_wdata);
      check("busy_access", {31'd0, busy}, 32'd1);
      mem_ready = (cnt == w + 1);
      mem_rdata = mem_ready ? rd_val : $urandom();
    end else begin
      if (in_txn) begin
        check("access_cycles", cnt, exp_len);
        check("done_owner", {31'd0, cur_owner ? d_done : if_done}, 32'd1);
        check("done_other", {31'd0, cur_owner ? if_done : d_done}, 32'd0);
        in_txn = 1'b0;
      end
      mem_ready = 1'($urandom_range(0, 1));
      mem_rdata = $urandom();
    end
  end

  // Response monitor: pops the scoreboard on each done pulse
  logic [31:0] exp_ir = '0, exp_dr = '0;
  always @(negedge clk) begin
    exp_t e;
    if (!resetn) begin
      exp_ir = '0;
      exp_dr = '0;
    end else begin
      if (if_done) begin
        if (if_q.size() == 0) check("if_done_expected", 32'd1, 32'd0);
        else begin
          e = if_q.pop_front();
          if (!e.keep) exp_ir = e.rdata;
          check("if_err", {31'd0, if_err}, {31'd0, e.err});
        end
      end
      if (d_done) begin
        if (d_q.size() == 0) check("d_done_expected", 32'd1, 32'd0);
        else begin
          e = d_q.pop_front();
          if (!e.keep) exp_dr = e.rdata;
          check("d_err", {31'd0, d_err}, {31'd0, e.err});
        end
      end
    end
    check("if_rdata", if_rdata, exp_ir);
    check("d_rdata", d_rdata, exp_dr);
  end

  function automatic logic [31:0] rnd_addr();
    logic [31:0] idx;
    idx = $urandom_range(0, 63);
    return ($urandom() & 32'hFFFF_FF00) | (idx << 2);
  endfunction

  task automatic fetch_txn(input logic [31:0] a, input int gap);
    int k;
    if_addr = a;
    if_req  = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (!if_done && k < 200);
    check("if_done_within_bound", {31'd0, if_done}, 32'd1);
    if (gap > 0 || !if_done) begin
      if_req = 1'b0;
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic data_txn(input logic we, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] ws, input int gap);
    int k;
    d_we    = we;
    d_addr  = a;
    d_wdata = wd;
    d_wstrb = ws;
    d_req   = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (!d_done && k < 200);
    check("d_done_within_bound", {31'd0, d_done}, 32'd1);
    if (gap > 0 || !d_done) begin
      d_req = 1'b0;
      repeat (gap) @(negedge clk);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    resetn = 1'b0; if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    for (int i = 0; i < 64; i++) mem_arr[i] = $urandom();
    repeat (3) @(negedge clk);
    check("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_if_done", {31'd0, if_done}, 32'd0);
    check("rst_d_done", {31'd0, d_done}, 32'd0);
    check("rst_if_err", {31'd0, if_err}, 32'd0);
    check("rst_d_err", {31'd0, d_err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_owner", {31'd0, owner}, 32'd0);
    #1 resetn = 1'b1;

    fork
      begin
        for (int i = 0; i < 50; i++)
          fetch_txn(rnd_addr(), (i == 49) ? 1 : int'($urandom_range(0, 2)));
      end
      begin
        for (int i = 0; i < 50; i++)
          data_txn(1'($urandom_range(0, 1)), rnd_addr(), $urandom(), 4'($urandom_range(0, 15)),
                   (i == 49) ? 1 : int'($urandom_range(0, 2)));
      end
    join

    // Reset in the middle of a hung fetch
    repeat (3) @(negedge clk);
    force_hang = 1'b1;
    if_addr = 32'h100;
    if_req  = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (!mem_valid && k < 20);
    check("hang_access_started", {31'd0, mem_valid}, 32'd1);
    @(negedge clk);
    #1 resetn = 1'b0;
    #1;
    check("midrst_mem_valid", {31'd0, mem_valid}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_if_done", {31'd0, if_done}, 32'd0);
    check("midrst_owner", {31'd0, owner}, 32'd0);
    if_req = 1'b0;
    force_hang = 1'b0;
    repeat (2) @(negedge clk);
    mem_arr[0] = 32'h0050_0093;
    #1 resetn = 1'b1;
    fetch_txn(32'h100, 0);
    check("refetch_rdata", if_rdata, 32'h0050_0093);
    check("refetch_err", {31'd0, if_err}, 32'd0);
    if_req = 1'b0;

    repeat (5) @(negedge clk);
    check("if_queue_drained", if_q.size(), 32'd0);
    check("d_queue_drained", d_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencer and arbiter for the single shared memory port of the multicycle core. It accepts instruction-fetch requests (IF stage) and load/store requests (ME stage), grants one at a time, and drives a ready-handshaked memory bus. It returns read data and a one-cycle completion pulse to the winning requester. A bus timeout converts a hung memory into an error response, so the control FSM never deadlocks.

## Interface
- ADDR_W, 32: address width
- DATA_W, 32: data width; strobe width is DATA_W/8
- TIMEOUT, 255: maximum ACCESS cycles without mem_ready; 0 disables the timeout
- STARVE_MAX, 4: number of consecutive data grants with fetch pending before fetch is forced
- clk  in  1  clock; all state changes on rising edge
- resetn  in  1  reset, asynchronous, active-low
- if_req  in  1  fetch request; level, held high with if_addr stable until if_done
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetch read data, valid with if_done
- if_done  out  1  one-cycle completion pulse for fetch
- if_err  out  1  timeout flag, valid only with if_done
- d_req  in  1  data request; level, held high with the payload stable until d_done
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_wstrb  in  DATA_W/8  store byte enables
- d_rdata  out  DATA_W  load data, valid with d_done
- d_done  out  1  one-cycle completion pulse for data
- d_err  out  1  timeout flag, valid only with d_done
- mem_valid  out  1  bus request
- mem_we  out  1  bus write enable
- mem_addr  out  ADDR_W  bus address
- mem_wdata  out  DATA_W  bus write data
- mem_wstrb  out  DATA_W/8  bus byte enables; all zero for reads
- mem_ready  in  1  bus completion; ignored while mem_valid=0
- mem_rdata  in  DATA_W  bus read data, sampled when mem_ready=1
- busy  out  1  high in ACCESS and RESP
- owner  out  1  current or last grant; 0 = fetch, 1 = data

## Operation
- FSM states: IDLE, ACCESS, RESP. Every output is registered or decoded from state and registers only.
- **IDLE**
  - If there is no request, stay in IDLE.
  - Otherwise pick a winner:
    - Default priority: data over fetch.
    - If starve_cnt == STARVE_MAX and if_req=1, fetch wins.
  - Latch the winner's addr, we, wdata and wstrb into bus registers. Fetch latches we=0 and wstrb=0.
  - Set owner, clear the timeout counter, go to ACCESS.
- **starve_cnt** (saturating at STARVE_MAX)
  - Incremented on each data grant made while if_req=1.
  - Cleared on each fetch grant.
- **ACCESS**
  - mem_valid=1; bus outputs hold stable.
  - If mem_ready=1: capture mem_rdata into the owner's rdata register (loads and fetches only; stores leave rdata unchanged), clear err, go to RESP.
  - Else if TIMEOUT≠0 and the counter has reached TIMEOUT-1: set err, write 0 to the owner's rdata, go to RESP.
  - Else increment the counter.
- **RESP**
  - mem_valid=0; pulse the owner's done for exactly one cycle; err is valid that cycle.
  - Requests are ignored in RESP. Always go to IDLE.
- The non-owner requester sees done=0 and its rdata unchanged.
- Requesters are required to drop req in the cycle after done, or immediately re-present a new request. The arbiter never re-grants a request within the same RESP cycle.

## Timing
- Reset (asynchronous, immediate) drives:
  - state IDLE
  - mem_valid, mem_we, mem_wstrb, if_done, d_done, if_err, d_err, busy, owner: 0
  - mem_addr, mem_wdata, if_rdata, d_rdata: 0
  - timeout counter and starve_cnt: 0
- Reset mid-ACCESS abandons the transaction; no done is issued.
- Latency:
  - req sampled high at edge k → mem_valid high from k+1.
  - mem_ready sampled at edge k+1+n (n ≥ 0) → done high during cycle k+2+n.
  - Minimum request-to-done latency is 3 edges (zero-wait memory).
- Back-to-back: the earliest next grant is the IDLE cycle after RESP, so throughput is at most one transaction per 3 cycles.
- Timeout: mem_valid stays high for exactly TIMEOUT cycles, then RESP with err=1.
- mem_ready arriving in the same edge as the timeout limit: ready wins and err=0.
- Simultaneous if_req and d_req in IDLE: resolved by the priority rules above. The loser's request stays pending and is served at the next IDLE.

## Test plan
- **Zero-wait fetch:** if_req=1, if_addr=0x100, mem_ready tied 1, mem_rdata=0x00500093.
  - mem_valid=1 for one cycle with mem_addr=0x100, mem_we=0, mem_wstrb=0.
  - if_done pulse 3 edges after request with if_rdata=0x00500093, if_err=0.
- **Store with waits:** d_req=1, d_we=1, d_addr=0x2000, d_wdata=0xDEADBEEF, d_wstrb=4'b0011; mem_ready after 3 cycles.
  - Bus payload holds stable for 4 cycles.
  - d_done once; d_rdata unchanged.
- **Simultaneous requests:** if_req and d_req high together, data as load from 0x40.
  - Data granted first (owner=1).
  - Fetch granted at the next IDLE; each done pulses exactly once.
- **Starvation:** d_req held high continuously with if_req=1 and STARVE_MAX=4.
  - 4 data grants, then a fetch grant, then data resumes.
- **Timeout:** TIMEOUT=8, mem_ready=0 on a load.
  - mem_valid high exactly 8 cycles, then d_done=1, d_err=1, d_rdata=0.
  - The next request proceeds normally.
- **Reset mid-access:** resetn low during ACCESS.
  - mem_valid=0 asynchronously; no done issued.
  - After release, a fresh fetch completes with correct data.
